rx_frame_writer: RTL and testbench

- Parametrised successor to the MAC Rx-to-buffer writer.
- Accepts 64-bit AXI-Stream frames from the 10G MAC Rx and writes them into a circular dual-port frame buffer, each frame in a slot: 2 header words, then data.
- Publishes completed frames by advancing `commited_wr_address`.
- Compared with the current writer, it adds:
  - parametrised buffer depth and threshold;
  - MAC-error frame discard;
  - a start-of-frame space check;
  - `wr_en` asserted only on real writes;
  - a commit that occurs only after both header words are written;
  - separate ok/full/error counters.

---
 rtl/rx_pkg.sv | 36 +++
 rtl/sat_counter32.sv | 17 +
 rtl/rx_frame_writer.sv | 179 +++++++++++++++++
 tb/tb_rx_frame_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and helpers for the MAC Rx frame writer.
package rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_HDR0 = 3'd2,
        ST_HDR1 = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    localparam int HDR_WORDS = 2;

    // s_axis_tuser field offsets
    localparam int TU_LEN = 0;
    localparam int TU_SRC = 16;
    localparam int TU_DST = 24;
    localparam int TU_TS  = 32;
    localparam int TU_ERR = 96;

    function automatic logic [63:0] pack_hdr0(input logic [15:0] len,
                                              input logic [7:0]  src,
                                              input logic [7:0]  dst);
        return {16'h0, len, 8'h0, dst, 8'h0, src};
    endfunction

    function automatic logic [15:0] strb_bytes(input logic [7:0] strb);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 16'(strb[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/rx_frame_writer.sv
// Writes MAC Rx frames into a circular buffer slot (2 header words + data) and commits them.
// Optional RX_STRB_LEN_EN: header length counted from beats/tstrb instead of tuser.
//
// state | meaning
// IDLE  | waiting for first beat of a frame
// DATA  | writing payload beats
// HDR0  | writing header word 0 at commit pointer
// HDR1  | writing header word 1, publishing the frame
// DROP  | swallowing the rest of a frame that ran out of space
module rx_frame_writer
    import rx_pkg::*;
#(
    parameter int AW      = 12,
    parameter int MAX_OCC = 2**AW - 64,
    parameter int ERR_BIT = TU_ERR
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [63:0]   s_axis_tdata,
    input  logic [7:0]    s_axis_tstrb,
    input  logic [127:0]  s_axis_tuser,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          wr_en,
    output logic [AW-1:0] commited_wr_address,
    input  logic [AW-1:0] commited_rd_address,
    output logic [31:0]   frames_ok_cnt,
    output logic [31:0]   drop_full_cnt,
    output logic [31:0]   drop_err_cnt
);

    localparam logic [AW-1:0] HDR_OFS   = AW'(HDR_WORDS);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW:0]   MAX_OCC_W = (AW+1)'(MAX_OCC);

    state_t        state;
    logic [AW-1:0] aux;
    logic [AW-1:0] occ;
    logic [AW-1:0] frame_start;
    logic [15:0]   len_q;
    logic [7:0]    src_q;
    logic [7:0]    dst_q;
    logic [63:0]   ts_q;
    logic [15:0]   len_first;
    logic [15:0]   len_next;
    logic          beat;
    logic          full;
    logic          err_flag;
    logic          in_frame;
    logic          inc_ok;
    logic          inc_full;
    logic          inc_err;
    logic          unused_inputs;

    assign beat        = s_axis_tvalid & s_axis_tready;
    assign full        = {1'b0, occ} > MAX_OCC_W;
    assign err_flag    = s_axis_tuser[ERR_BIT];
    assign frame_start = commited_wr_address + HDR_OFS;
    assign in_frame    = (state == ST_IDLE) || (state == ST_DATA);

`ifdef RX_STRB_LEN_EN
    assign len_first     = s_axis_tlast ? strb_bytes(s_axis_tstrb) : 16'd8;
    assign len_next      = len_q + len_first;
    assign unused_inputs = ^s_axis_tuser;
`else
    assign len_first     = s_axis_tuser[TU_LEN +: 16];
    assign len_next      = len_q;
    assign unused_inputs = ^{s_axis_tuser, s_axis_tstrb};
`endif

    // Space drop wins over MAC error: a full frame never reaches the error check.
    assign inc_ok   = (state == ST_HDR1);
    assign inc_full = beat & s_axis_tlast & ((in_frame & full) | (state == ST_DROP));
    assign inc_err  = beat & s_axis_tlast & in_frame & ~full & err_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= ST_IDLE;
            aux                 <= HDR_OFS;
            occ                 <= '0;
            len_q               <= '0;
            src_q               <= '0;
            dst_q               <= '0;
            ts_q                <= '0;
            s_axis_tready       <= 1'b1;
            wr_en               <= 1'b0;
            wr_addr             <= '0;
            wr_data             <= '0;
            commited_wr_address <= '0;
        end else begin
            wr_en <= 1'b0;
            occ   <= aux - commited_rd_address;
            case (state)
                ST_IDLE, ST_DATA: begin
                    if (beat) begin
                        if (state == ST_IDLE) begin
                            len_q <= len_first;
                            src_q <= s_axis_tuser[TU_SRC +: 8];
                            dst_q <= s_axis_tuser[TU_DST +: 8];
                            ts_q  <= s_axis_tuser[TU_TS +: 64];
                        end else begin
                            len_q <= len_next;
                        end
                        if (full) begin
                            aux   <= frame_start;
                            state <= s_axis_tlast ? ST_IDLE : ST_DROP;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= aux;
                            wr_data <= s_axis_tdata;
                            if (!s_axis_tlast) begin
                                aux   <= aux + ONE;
                                state <= ST_DATA;
                            end else if (err_flag) begin
                                aux   <= frame_start;
                                state <= ST_IDLE;
                            end else begin
                                aux           <= aux + ONE;
                                s_axis_tready <= 1'b0;
                                state         <= ST_HDR0;
                            end
                        end
                    end
                end
                ST_HDR0: begin
                    wr_en   <= 1'b1;
                    wr_addr <= commited_wr_address;
                    wr_data <= pack_hdr0(len_q, src_q, dst_q);
                    state   <= ST_HDR1;
                end
                ST_HDR1: begin
                    wr_en               <= 1'b1;
                    wr_addr             <= commited_wr_address + ONE;
                    wr_data             <= ts_q;
                    commited_wr_address <= aux;
                    aux                 <= aux + HDR_OFS;
                    s_axis_tready       <= 1'b1;
                    state               <= ST_IDLE;
                end
                ST_DROP: begin
                    aux <= frame_start;
                    if (beat && s_axis_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    aux           <= frame_start;
                    s_axis_tready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter32 u_ok_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_ok),
        .count   (frames_ok_cnt)
    );

    sat_counter32 u_full_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_full),
        .count   (drop_full_cnt)
    );

    sat_counter32 u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_err),
        .count   (drop_err_cnt)
    );

endmodule

// File: tb/tb_rx_frame_writer.sv
// Scoreboard bench for rx_frame_writer: expected buffer writes queued by stimulus, popped by a monitor.
module tb_rx_frame_writer;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tstrb;
    logic [127:0]  s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          wr_en;
    logic [AW-1:0] commited_wr_address;
    logic [AW-1:0] commited_rd_address;
    logic [31:0]   frames_ok_cnt;
    logic [31:0]   drop_full_cnt;
    logic [31:0]   drop_err_cnt;

    always #5 clk = ~clk;

    rx_frame_writer #(.AW(AW), .MAX_OCC(32), .ERR_BIT(96)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tstrb        (s_axis_tstrb),
        .s_axis_tuser        (s_axis_tuser),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tready       (s_axis_tready),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_en               (wr_en),
        .commited_wr_address (commited_wr_address),
        .commited_rd_address (commited_rd_address),
        .frames_ok_cnt       (frames_ok_cnt),
        .drop_full_cnt       (drop_full_cnt),
        .drop_err_cnt        (drop_err_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] mc;
    logic [AW-1:0] ma;
    int            n_ok;
    int            n_full;
    int            n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                check("wr_data", wr_data, mon_e.data);
            end
        end
    end

    task automatic check_reset();
        check("rst_tready", 64'(s_axis_tready), 64'd1);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_commit", 64'(commited_wr_address), 64'd0);
        check("rst_ok_cnt", 64'(frames_ok_cnt), 64'd0);
        check("rst_full_cnt", 64'(drop_full_cnt), 64'd0);
        check("rst_err_cnt", 64'(drop_err_cnt), 64'd0);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] strb,
                             input logic [127:0] user, input logic last);
        int wait_n;
        s_axis_tdata  = d;
        s_axis_tstrb  = strb;
        s_axis_tuser  = user;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        wait_n = 0;
        while (!s_axis_tready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!s_axis_tready) begin
            checks++;
            errors++;
            $display("FAIL tready_timeout: tready %0d after %0d cycles, expected 1", s_axis_tready, wait_n);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // keep = number of leading beats expected in the buffer (less than n for a space drop)
    task automatic send_frame(input int id, input int n, input int keep, input logic [15:0] len,
                              input logic [7:0] src, input logic [7:0] dst, input logic [63:0] ts,
                              input logic err, input logic [7:0] strb_last, input int gap);
        logic [127:0] user;
        logic [63:0]  d;
        logic [15:0]  exp_len;
        logic         good;
        int           low;
        ma   = mc + AW'(2);
        good = (keep == n) && !err;
        for (int k = 0; k < n; k++) begin
            user          = '0;
            user[15:0]    = len;
            user[23:16]   = src;
            user[31:24]   = dst;
            user[95:32]   = ts;
            user[96]      = err && (k == n - 1);
            d = {16'hDA7A, 16'(id), 32'(k)};
            if (k < keep) push_wr(ma + AW'(k), d);
            send_beat(d, (k == n - 1) ? strb_last : 8'hFF, user, k == n - 1);
            if (k != n - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
`ifdef RX_STRB_LEN_EN
        exp_len = 16'(8 * (n - 1)) + 16'($countones(strb_last));
`else
        exp_len = len;
`endif
        if (good) begin
            push_wr(mc, {16'h0, exp_len, 8'h0, dst, 8'h0, src});
            push_wr(mc + AW'(1), ts);
        end
        low = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (s_axis_tready) break;
            low++;
        end
        check("tready_low_cycles", 64'(low), good ? 64'd2 : 64'd0);
        if (good) begin
            mc = ma + AW'(n);
            n_ok++;
        end else if (keep < n) begin
            n_full++;
        end else begin
            n_err++;
        end
        check("commit", 64'(commited_wr_address), 64'(mc));
        check("frames_ok_cnt", 64'(frames_ok_cnt), 64'(n_ok));
        check("drop_full_cnt", 64'(drop_full_cnt), 64'(n_full));
        check("drop_err_cnt", 64'(drop_err_cnt), 64'(n_err));
        @(posedge clk);
        #1;
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n             = 1'b0;
        s_axis_tdata        = '0;
        s_axis_tstrb        = '0;
        s_axis_tuser        = '0;
        s_axis_tvalid       = 1'b0;
        s_axis_tlast        = 1'b0;
        commited_rd_address = '0;
        mc                  = '0;
        ma                  = '0;
        n_ok                = 0;
        n_full              = 0;
        n_err               = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 3-beat frame: data 2..4, headers 0/1, commit 5
        send_frame(1, 3, 3, 16'd20, 8'd1, 8'd2, 64'hAB, 1'b0, 8'h0F, 0);
        commited_rd_address = mc;
        // single beat: data 7, headers 5/6, commit 8
        send_frame(2, 1, 1, 16'd8, 8'd3, 8'd4, 64'h1234, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;
        // MAC error on last beat: written at 10..12, never committed
        send_frame(3, 3, 3, 16'd20, 8'd1, 8'd2, 64'hAB, 1'b1, 8'h0F, 0);
        // next good frame reuses data address 10
        send_frame(4, 2, 2, 16'd16, 8'd5, 8'd6, 64'hCD, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;

        // reset in the middle of a frame
        ma = mc + AW'(2);
        push_wr(ma, 64'hDA7A_0005_0000_0000);
        send_beat(64'hDA7A_0005_0000_0000, 8'hFF, 128'h0, 1'b0);
        push_wr(ma + AW'(1), 64'hDA7A_0005_0000_0001);
        send_beat(64'hDA7A_0005_0000_0001, 8'hFF, 128'h0, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #2;
        check_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mc = '0;
        n_ok = 0;
        n_full = 0;
        n_err = 0;
        commited_rd_address = '0;
        check("pending_after_reset", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // 40 beats with rd=0: occupancy exceeds 32 at beat 32, beats 0..31 land at 2..33
        send_frame(6, 40, 32, 16'd320, 8'd7, 8'd8, 64'h77, 1'b0, 8'hFF, 0);
        send_frame(7, 3, 3, 16'd24, 8'd9, 8'd10, 64'h88, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;

        // walk the commit pointer up to 63
        send_frame(8, 12, 12, 16'd96, 8'd1, 8'd1, 64'h101, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;
        send_frame(9, 12, 12, 16'd96, 8'd2, 8'd2, 64'h102, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;
        send_frame(10, 13, 13, 16'd104, 8'd3, 8'd3, 64'h103, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;
        send_frame(11, 13, 13, 16'd104, 8'd4, 8'd4, 64'h104, 1'b0, 8'hFF, 0);
        commited_rd_address = mc;
        check("commit_at_top", 64'(commited_wr_address), 64'd63);

        // wrap: headers at 63/0, data 1..3, commit 4, with tvalid gaps
        send_frame(12, 3, 3, 16'd24, 8'h11, 8'h22, 64'hFEED_0000_0000_BEEF, 1'b0, 8'hFF, 2);
        commited_rd_address = mc;

        // header length from tuser (999) or, with RX_STRB_LEN_EN, from beats (11)
        send_frame(13, 2, 2, 16'd999, 8'd9, 8'd10, 64'hEE, 1'b0, 8'h07, 0);

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
